// File: rtl/display_scanner.sv
// display_scanner: time-multiplexed scan controller for a multi-digit seven-segment display
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   value        : packed 4-bit digit codes, value[3:0] is the rightmost digit
//   blank_lz     : suppress leading zero digits (sampled every cycle)
//   bcd          : registered code of the digit in the current slot
//   digit_en     : registered one-hot digit enable, all zero when the digit is blanked
//   frame_start  : registered one-cycle pulse on each edge that takes a new snapshot
module display_scanner #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  blank_lz,
    output logic [3:0]            bcd,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  frame_start
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    typedef enum logic {IDLE, SCAN} state_t;
    state_t              state_q, state_d;
    logic [PW-1:0]       pcnt_q, pcnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic [3:0]          bcd_q, bcd_d;
    logic [DIGITS-1:0]   en_q, en_d;
    logic                fs_q, fs_d;
    logic                tick;
    logic                blanked;
    always_comb begin
        state_d  = state_q;
        pcnt_d   = pcnt_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        fs_d     = 1'b0;
        tick     = pcnt_q == PW'(PRESCALE - 1);
        if (state_q == IDLE) begin
            state_d  = SCAN;
            shadow_d = value;
            idx_d    = '0;
            pcnt_d   = '0;
            fs_d     = 1'b1;
        end else if (tick) begin
            pcnt_d = '0;
            if (idx_q == IW'(DIGITS - 1)) begin
                idx_d    = '0;
                shadow_d = value;
                fs_d     = 1'b1;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end else begin
            pcnt_d = pcnt_q + PW'(1);
        end
        // Outputs follow the next-state index so they change on the same edge as idx.
        bcd_d   = shadow_d[4*idx_d +: 4];
        // A digit is a leading zero when it and every nibble above it are zero.
        blanked = blank_lz && idx_d != '0 && (shadow_d >> (4*idx_d)) == '0;
        en_d    = blanked ? '0 : DIGITS'(1) << idx_d;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pcnt_q   <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            bcd_q    <= 4'h0;
            en_q     <= '0;
            fs_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            pcnt_q   <= pcnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            bcd_q    <= bcd_d;
            en_q     <= en_d;
            fs_q     <= fs_d;
        end
    end
    assign bcd         = bcd_q;
    assign digit_en    = en_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_display_scanner.sv
// tb_display_scanner: checks display_scanner (DIGITS=4) at PRESCALE=4 and PRESCALE=1
module tb_display_scanner;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = 16'h1234;
    logic        blank_lz = 1'b0;
    logic [3:0]  bcd4, bcd1;
    logic [3:0]  en4, en1;
    logic        fs4, fs1;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    display_scanner #(.DIGITS(4), .PRESCALE(4)) dut4 (
        .clk(clk), .rst(rst), .value(value), .blank_lz(blank_lz),
        .bcd(bcd4), .digit_en(en4), .frame_start(fs4));
    display_scanner #(.DIGITS(4), .PRESCALE(1)) dut1 (
        .clk(clk), .rst(rst), .value(value), .blank_lz(blank_lz),
        .bcd(bcd1), .digit_en(en1), .frame_start(fs1));

    // Reference: k counts edges since the IDLE->SCAN edge; the slot, frame boundary
    // and snapshot follow directly from k with plain arithmetic.
    int          k4 = -1, k1 = -1;
    logic [15:0] s4 = '0, s1 = '0;
    logic        b4 = 1'b0, b1 = 1'b0;

    always @(posedge clk) begin
        b4 = blank_lz;
        b1 = blank_lz;
        if (rst) begin
            k4 = -1; s4 = '0;
            k1 = -1; s1 = '0;
        end else begin
            k4++;
            k1++;
            if (k4 % 16 == 0) s4 = value;
            if (k1 % 4 == 0) s1 = value;
        end
    end

    // {frame_start, digit_en, bcd}
    function automatic logic [8:0] model(int k, int p, logic [15:0] s, logic b);
        int          slot;
        logic [15:0] up;
        logic [3:0]  en;
        if (k < 0) return 9'h0;
        slot = (k / p) % 4;
        up   = s >> (4 * slot);
        en   = (b && slot > 0 && up == 16'h0) ? 4'b0000 : 4'b0001 << slot;
        return {k % (4 * p) == 0, en, up[3:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        chk("model_p4", {23'h0, fs4, en4, bcd4}, {23'h0, model(k4, 4, s4, b4)});
        chk("model_p1", {23'h0, fs1, en1, bcd1}, {23'h0, model(k1, 1, s1, b1)});
        chk("onehot_p4", 32'($countones(en4) <= 1), 32'd1);
        chk("onehot_p1", 32'($countones(en1) <= 1), 32'd1);
    endtask

    task automatic wait_fs();
        for (int i = 0; i < 40; i++) begin
            step();
            if (fs4) break;
        end
        chk("fs_wait", {31'h0, fs4}, 32'd1);
    endtask

    task automatic chk_out(input string name, input logic fs, input logic [3:0] en, input logic [3:0] b);
        chk(name, {23'h0, fs4, en4, bcd4}, {23'h0, fs, en, b});
    endtask

    typedef struct {
        logic [15:0] value;
        logic        blank;
        logic [15:0] en;
        logic [15:0] bcd;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{16'h1234, 1'b0, 16'h8421, 16'h1234};
        vecs[1] = '{16'h0050, 1'b1, 16'h0021, 16'h0050};
        vecs[2] = '{16'h0000, 1'b1, 16'h0001, 16'h0000};
        vecs[3] = '{16'h1000, 1'b1, 16'h8421, 16'h1000};
        vecs[4] = '{16'h0050, 1'b0, 16'h8421, 16'h0050};
        vecs[5] = '{16'h0A00, 1'b1, 16'h0421, 16'h0A00};

        // Reset held for three cycles
        repeat (3) begin
            step();
            chk_out("reset_hold", 1'b0, 4'b0000, 4'h0);
        end
        rst = 1'b0;
        step();
        chk_out("first_frame", 1'b1, 4'b0001, 4'h4);
        chk("first_frame_p1", {23'h0, fs1, en1, bcd1}, {23'h0, 1'b1, 4'b0001, 4'h4});

        // PRESCALE=1 rotates every cycle, frame_start every 4th
        for (int j = 1; j <= 4; j++) begin
            step();
            chk("p1_rotate", {28'h0, en1}, {28'h0, 4'b0001 << (j % 4)});
            chk("p1_fs", {31'h0, fs1}, {31'h0, j == 4});
        end

        // Scan order at PRESCALE=4 (now at slot 1 start)
        chk_out("scan_d1", 1'b0, 4'b0010, 4'h3);
        repeat (4) step();
        chk_out("scan_d2", 1'b0, 4'b0100, 4'h2);
        repeat (4) step();
        chk_out("scan_d3", 1'b0, 4'b1000, 4'h1);
        repeat (4) step();
        chk_out("scan_wrap", 1'b1, 4'b0001, 4'h4);

        // Value change in slot 1 must not tear the current frame
        repeat (5) step();
        value = 16'hABCD;
        repeat (3) step();
        chk_out("snap_d2", 1'b0, 4'b0100, 4'h2);
        repeat (4) step();
        chk_out("snap_d3", 1'b0, 4'b1000, 4'h1);
        repeat (4) step();
        chk_out("snap_new0", 1'b1, 4'b0001, 4'hD);
        repeat (4) step();
        chk_out("snap_new1", 1'b0, 4'b0010, 4'hC);
        repeat (4) step();
        chk_out("snap_new2", 1'b0, 4'b0100, 4'hB);
        repeat (4) step();
        chk_out("snap_new3", 1'b0, 4'b1000, 4'hA);

        // Reset during the digit 2 slot
        repeat (12) step();
        chk_out("pre_midreset", 1'b0, 4'b0100, 4'hB);
        value = 16'h1234;
        rst = 1'b1;
        step();
        chk_out("midreset", 1'b0, 4'b0000, 4'h0);
        rst = 1'b0;
        step();
        chk_out("midreset_release", 1'b1, 4'b0001, 4'h4);
        repeat (4) step();
        chk_out("midreset_d1", 1'b0, 4'b0010, 4'h3);

        // Table: each record is captured at a frame boundary, then every slot checked
        for (int v = 0; v < 6; v++) begin
            logic [15:0] te, tb;
            te = vecs[v].en;
            tb = vecs[v].bcd;
            value    = vecs[v].value;
            blank_lz = vecs[v].blank;
            wait_fs();
            for (int s = 0; s < 4; s++) begin
                chk($sformatf("vec%0d_slot%0d", v, s), {24'h0, en4, bcd4}, {24'h0, te[4*s +: 4], tb[4*s +: 4]});
                if (s < 3) repeat (4) step();
            end
        end

        // Random value/blank/reset activity against the model
        for (int c = 0; c < 2000; c++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 8) begin
                logic [15:0] m;
                for (int q = 0; q < 4; q++) m[4*q +: 4] = $urandom_range(0, 1) ? 4'hF : 4'h0;
                value = 16'($urandom) & m;
            end
            if (r >= 8 && r < 12) blank_lz = ~blank_lz;
            rst = (r == 12);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
